mem_copy_engine: RTL and testbench

Block-copy engine sitting directly upstream of the data memory. Owns the memory's single address/read/write port. Passes CPU load/store traffic straight through when idle. On command, copies `Len` bytes from `SrcAddr` to `DstAddr` by alternating read and write cycles, stalling the CPU for the duration.

---
 rtl/mem_copy_engine_if.sv | 38 +++
 rtl/mem_copy_engine.sv | 92 +++++++++
 tb/tb_mem_copy_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - CPU, memory and copy-command signals of the block-copy engine
interface mem_copy_engine_if;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [7:0] Len;
    logic [7:0] CpuAddress;
    logic       CpuReadMem;
    logic       CpuWriteMem;
    logic [7:0] CpuDataIn;
    logic [7:0] CpuDataOut;
    logic       CpuStall;
    logic [7:0] MemAddress;
    logic       MemReadMem;
    logic       MemWriteMem;
    logic [7:0] MemDataIn;
    logic [7:0] MemDataOut;
    logic       Busy;
    logic       Done;

    modport slave (
        input  Start, SrcAddr, DstAddr, Len,
        input  CpuAddress, CpuReadMem, CpuWriteMem, CpuDataIn,
        output CpuDataOut, CpuStall,
        output MemAddress, MemReadMem, MemWriteMem, MemDataIn,
        input  MemDataOut,
        output Busy, Done
    );

    modport master (
        output Start, SrcAddr, DstAddr, Len,
        output CpuAddress, CpuReadMem, CpuWriteMem, CpuDataIn,
        input  CpuDataOut, CpuStall,
        input  MemAddress, MemReadMem, MemWriteMem, MemDataIn,
        output MemDataOut,
        input  Busy, Done
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block-copy engine owning the data memory port, CPU pass-through when idle
module mem_copy_engine (
    input  logic                      CLK,
    input  logic                      reset,
    mem_copy_engine_if.slave          bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state;
    logic [7:0] src_ptr;
    logic [7:0] dst_ptr;
    logic [7:0] cnt;
    logic [7:0] buf_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            src_ptr <= 8'd0;
            dst_ptr <= 8'd0;
            cnt     <= 8'd0;
            buf_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        src_ptr <= bus.SrcAddr;
                        dst_ptr <= bus.DstAddr;
                        cnt     <= bus.Len;
                        if (bus.Len == 8'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RD;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    // Memory read is combinational, so the byte is captured in its address cycle
                    buf_q <= bus.MemDataOut;
                    state <= WR;
                end
                WR: begin
                    src_ptr <= src_ptr + 8'd1;
                    dst_ptr <= dst_ptr + 8'd1;
                    cnt     <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                default: begin
                    // DONE: Start is deliberately not sampled here
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.MemAddress  = bus.CpuAddress;
        bus.MemReadMem  = bus.CpuReadMem;
        bus.MemWriteMem = bus.CpuWriteMem;
        bus.MemDataIn   = bus.CpuDataIn;
        bus.CpuDataOut  = bus.MemDataOut;
        if (state == RD) begin
            bus.MemAddress  = src_ptr;
            bus.MemReadMem  = 1'b1;
            bus.MemWriteMem = 1'b0;
            bus.CpuDataOut  = 8'd0;
        end else if (state == WR) begin
            bus.MemAddress  = dst_ptr;
            bus.MemReadMem  = 1'b0;
            bus.MemWriteMem = 1'b1;
            bus.MemDataIn   = buf_q;
            bus.CpuDataOut  = 8'd0;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.CpuStall = busy_q;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine with a behavioural memory
module tb_mem_copy_engine;
    logic CLK = 1'b0;
    logic reset;
    mem_copy_engine_if b();

    mem_copy_engine dut (.CLK(CLK), .reset(reset), .bus(b));

    always #5 CLK = ~CLK;

    logic [7:0] mem  [256];
    logic [7:0] refm [256];

    assign b.MemDataOut = mem[b.MemAddress];
    always @(posedge CLK) if (b.MemWriteMem) mem[b.MemAddress] <= b.MemDataIn;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [7:0]      len;
        logic [2:0]      npre;
        logic [3:0][7:0] pre;   // pre[j] lands at src+j
        logic [2:0]      nexp;
        logic [3:0][7:0] exp;   // exp[j] expected at dst+j
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic snap_ref();
        for (int i = 0; i < 256; i++) refm[i] = mem[i];
    endtask

    // Forward byte-by-byte copy on 8-bit wrapping addresses
    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        logic [7:0] si, di;
        si = s;
        di = d;
        for (int i = 0; i < int'(l); i++) begin
            refm[di] = refm[si];
            si = si + 8'd1;
            di = di + 8'd1;
        end
    endtask

    function automatic int mem_mismatch();
        int m = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) m++;
        return m;
    endfunction

    // Issues Start and watches Busy/CpuStall/Done for the whole expected window
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            output int tviol);
        int n;
        logic eb, ed;
        n = int'(l);
        b.Start = 1'b1; b.SrcAddr = s; b.DstAddr = d; b.Len = l;
        @(posedge CLK); #1;
        b.Start = 1'b0; b.SrcAddr = 8'($urandom); b.DstAddr = 8'($urandom); b.Len = 8'($urandom);
        tviol = 0;
        for (int c = 1; c <= 2 * n + 3; c++) begin
            eb = (n != 0) && (c <= 2 * n);
            ed = (n == 0) ? (c == 1) : (c == 2 * n + 1);
            if (b.Busy !== eb || b.CpuStall !== eb || b.Done !== ed) tviol++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int tv, bad, early, zviol, dcnt, dcyc, stalls, busy_after;
        logic [7:0] s, d, l, a;

        vecs[0] = '{src:8'h10, dst:8'h80, len:8'd4, npre:3'd4, pre:{8'hD4,8'hC3,8'hB2,8'hA1},
                    nexp:3'd4, exp:{8'hD4,8'hC3,8'hB2,8'hA1}};
        vecs[1] = '{src:8'h10, dst:8'h80, len:8'd0, npre:3'd0, pre:32'h0, nexp:3'd0, exp:32'h0};
        vecs[2] = '{src:8'hFE, dst:8'h40, len:8'd4, npre:3'd4, pre:{8'h04,8'h03,8'h02,8'h01},
                    nexp:3'd4, exp:{8'h04,8'h03,8'h02,8'h01}};
        vecs[3] = '{src:8'h20, dst:8'h21, len:8'd3, npre:3'd1, pre:{24'h0,8'h5A},
                    nexp:3'd3, exp:{8'h00,8'h5A,8'h5A,8'h5A}};
        vecs[4] = '{src:8'h7F, dst:8'h7F, len:8'd1, npre:3'd1, pre:{24'h0,8'h3C},
                    nexp:3'd1, exp:{24'h0,8'h3C}};
        vecs[5] = '{src:8'h05, dst:8'hFF, len:8'd2, npre:3'd2, pre:{16'h0,8'h08,8'h09},
                    nexp:3'd2, exp:{16'h0,8'h08,8'h09}};

        b.Start = 0; b.SrcAddr = 0; b.DstAddr = 0; b.Len = 0;
        b.CpuAddress = 0; b.CpuReadMem = 0; b.CpuWriteMem = 0; b.CpuDataIn = 0;
        rand_mem();
        reset = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        // Reset state and pass-through with random CPU request
        b.CpuAddress = 8'($urandom); b.CpuDataIn = 8'($urandom);
        b.CpuReadMem = 1'b1; b.CpuWriteMem = 1'b1;
        #1;
        chk("rst_busy", b.Busy, 0);
        chk("rst_done", b.Done, 0);
        chk("rst_stall", b.CpuStall, 0);
        chk("rst_pt_addr", b.MemAddress, b.CpuAddress);
        chk("rst_pt_wdata", b.MemDataIn, b.CpuDataIn);
        chk("rst_pt_we_re", {b.MemWriteMem, b.MemReadMem}, 2'b11);
        chk("rst_pt_rdata", b.CpuDataOut, mem[b.CpuAddress]);
        b.CpuWriteMem = 1'b0; b.CpuReadMem = 1'b0;
        reset = 1'b0;
        @(posedge CLK); #1;

        foreach (vecs[v]) begin
            rand_mem();
            for (int j = 0; j < int'(vecs[v].npre); j++) begin
                a = vecs[v].src + 8'(j);
                mem[a] = vecs[v].pre[j];
            end
            snap_ref();
            ref_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, tv);
            chk($sformatf("vec%0d_timing", v), tv, 0);
            bad = 0;
            for (int j = 0; j < int'(vecs[v].nexp); j++) begin
                a = vecs[v].dst + 8'(j);
                if (mem[a] !== vecs[v].exp[j]) bad++;
            end
            chk($sformatf("vec%0d_dst_bytes", v), bad, 0);
            chk($sformatf("vec%0d_mem", v), mem_mismatch(), 0);
        end

        for (int r = 0; r < 8; r++) begin
            rand_mem();
            s = 8'($urandom); d = 8'($urandom);
            l = (r == 0) ? 8'd255 : 8'($urandom_range(0, 40));
            snap_ref();
            ref_copy(s, d, l);
            run_copy(s, d, l, tv);
            chk($sformatf("rand%0d_timing", r), tv, 0);
            chk($sformatf("rand%0d_mem", r), mem_mismatch(), 0);
        end

        // CPU write held through a Len=4 copy, plus an ignored mid-copy Start
        rand_mem();
        mem[8'h90] = 8'h00;
        snap_ref();
        ref_copy(8'h10, 8'h80, 8'd4);
        refm[8'h90] = 8'h77;
        b.Start = 1'b1; b.SrcAddr = 8'h10; b.DstAddr = 8'h80; b.Len = 8'd4;
        @(posedge CLK); #1;
        b.Start = 1'b0;
        b.CpuWriteMem = 1'b1; b.CpuAddress = 8'h90; b.CpuDataIn = 8'h77;
        early = 0; zviol = 0; dcnt = 0; dcyc = 0; stalls = 0; busy_after = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                b.Start = 1'b1; b.SrcAddr = 8'h00; b.DstAddr = 8'hC0; b.Len = 8'd5;
                #1;
            end else begin
                b.Start = 1'b0;
            end
            if (b.CpuStall) begin
                stalls++;
                if (mem[8'h90] == 8'h77) early++;
                if (b.CpuDataOut !== 8'h00) zviol++;
            end
            if (b.Done) begin dcnt++; dcyc = c; end
            if (c > 9 && b.Busy) busy_after++;
            if (c == 10) chk("cont_write_landed", mem[8'h90], 8'h77);
            @(posedge CLK); #1;
        end
        b.CpuWriteMem = 1'b0;
        chk("cont_stall_cycles", stalls, 8);
        chk("cont_early_write", early, 0);
        chk("cont_dataout_zero", zviol, 0);
        chk("cont_done_count", dcnt, 1);
        chk("cont_done_cycle", dcyc, 9);
        chk("cont_second_start", busy_after, 0);
        chk("cont_mem", mem_mismatch(), 0);

        // Reset after the second WR of a Len=4 copy
        rand_mem();
        snap_ref();
        ref_copy(8'h30, 8'hA0, 8'd2);
        b.Start = 1'b1; b.SrcAddr = 8'h30; b.DstAddr = 8'hA0; b.Len = 8'd4;
        @(posedge CLK); #1;
        b.Start = 1'b0;
        for (int c = 1; c <= 4; c++) begin @(posedge CLK); #1; end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        b.CpuAddress = 8'h55; b.CpuReadMem = 1'b1;
        #1;
        chk("rstmid_busy", b.Busy, 0);
        chk("rstmid_done", b.Done, 0);
        chk("rstmid_pt_addr", b.MemAddress, 8'h55);
        chk("rstmid_pt_rdata", b.CpuDataOut, mem[8'h55]);
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (b.Done || b.Busy) dcnt++;
            @(posedge CLK); #1;
        end
        b.CpuReadMem = 1'b0;
        chk("rstmid_quiet", dcnt, 0);
        chk("rstmid_mem", mem_mismatch(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
